// File: rtl/alu_issue_if.sv
// ---------------------------------------------------------------------------
// alu_issue_if
// Bundles every non-clock/reset signal of alu_issue_unit.
//   instr / instr_valid / instr_ready     : instruction stream into the unit
//   alu_operand1/2, alu_operation         : operands and opcode sent to the ALU
//   alu_result                            : combinational result from the ALU
//   out_data / out_valid / out_ready      : register values streamed out
//   zero_flag                             : last ALU result was zero
// Modports:
//   slave  - the issue unit's view (it accepts instructions)
//   master - the surrounding system's view (source, ALU and sink)
// ---------------------------------------------------------------------------
interface alu_issue_if #(
    parameter int DATA_WIDTH = 16
);
    logic [15:0]           instr;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] alu_operand1;
    logic [DATA_WIDTH-1:0] alu_operand2;
    logic [3:0]            alu_operation;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  zero_flag;

    modport slave (
        input  instr, instr_valid, alu_result, out_ready,
        output instr_ready, alu_operand1, alu_operand2, alu_operation,
               out_data, out_valid, zero_flag
    );

    modport master (
        output instr, instr_valid, alu_result, out_ready,
        input  instr_ready, alu_operand1, alu_operand2, alu_operation,
               out_data, out_valid, zero_flag
    );
endinterface

// File: rtl/alu_issue_unit.sv
// ---------------------------------------------------------------------------
// alu_issue_unit
// Sequential initiator for a 16-bit combinational ALU. Accepts instruction
// words over a valid/ready handshake, keeps a small register file, drives the
// ALU with registered operands for one EXEC cycle, writes the ALU result back
// and streams selected registers out over a second valid/ready port.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous, active-high reset
//   bus    - alu_issue_if.slave (instruction in, ALU side, output stream,
//            zero_flag)
//
// Instruction word: op[15:13] rd[12:10] rs1[9:7] rs2[6:4] imm[7:0]
//   000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR : rd <= rs1 op rs2
//   101 LDI : rd <= zero-extended imm
//   110 OUT : emit reg[rs1]
//   111 NOP
//
// Optional feature macro: ALU_ISSUE_ZERO_FLAG_EN
//   defined   - zero_flag registers (alu_result == 0) at each ALU writeback
//   undefined - zero_flag is constant 0
// ---------------------------------------------------------------------------
module alu_issue_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_COUNT  = 8
) (
    input logic       clk,
    input logic       reset,
    alu_issue_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        OUT_WAIT = 2'd2
    } state_t;

    localparam logic [2:0] OP_LDI = 3'b101;
    localparam logic [2:0] OP_OUT = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    // Register indices are 3 bits wide; anything at or above this limit reads
    // as zero and is never written, so smaller register files behave as if
    // the missing registers were hard-wired to zero.
    localparam logic [3:0] REG_LIMIT = 4'(REG_COUNT);

    state_t                state;
    logic [DATA_WIDTH-1:0] regs [8];
    logic                  instr_ready_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [DATA_WIDTH-1:0] operand1_q;
    logic [DATA_WIDTH-1:0] operand2_q;
    logic [3:0]            operation_q;
    logic [2:0]            exec_rd;

    logic [2:0]            op;
    logic [2:0]            rd;
    logic [2:0]            rs1;
    logic [2:0]            rs2;
    logic [7:0]            imm;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [DATA_WIDTH-1:0] rs1_val;
    logic [DATA_WIDTH-1:0] rs2_val;
    logic                  rd_writable;
    logic                  exec_rd_writable;
    logic                  accept;

    // Field decode straight off the instruction bus; only used on a transfer
    // edge, when the source guarantees instr is stable.
    assign op      = bus.instr[15:13];
    assign rd      = bus.instr[12:10];
    assign rs1     = bus.instr[9:7];
    assign rs2     = bus.instr[6:4];
    assign imm     = bus.instr[7:0];
    assign imm_ext = {{(DATA_WIDTH-8){1'b0}}, imm};

    assign rs1_val          = ({1'b0, rs1} < REG_LIMIT) ? regs[rs1] : '0;
    assign rs2_val          = ({1'b0, rs2} < REG_LIMIT) ? regs[rs2] : '0;
    assign rd_writable      = ({1'b0, rd} < REG_LIMIT);
    assign exec_rd_writable = ({1'b0, exec_rd} < REG_LIMIT);

    // instr_ready_q is only ever high while in IDLE, so it doubles as the
    // state qualifier for a transfer.
    assign accept = bus.instr_valid && instr_ready_q;

    assign bus.instr_ready   = instr_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_data      = out_data_q;
    assign bus.alu_operand1  = operand1_q;
    assign bus.alu_operand2  = operand2_q;
    assign bus.alu_operation = operation_q;

    // Main sequencer: decodes accepted instructions, owns the register file
    // and all registered outputs. The ALU operands are loaded on the accept
    // edge so they are stable for the entire EXEC cycle, and the ALU result
    // is written back on the edge that ends EXEC. instr_ready comes up one
    // edge after reset release, so nothing is accepted on that first edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            instr_ready_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            operand1_q    <= '0;
            operand2_q    <= '0;
            operation_q   <= 4'b0000;
            exec_rd       <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    instr_ready_q <= 1'b1;
                    if (accept) begin
                        case (op)
                            OP_LDI: begin
                                if (rd_writable) begin
                                    regs[rd] <= imm_ext;
                                end
                            end
                            OP_OUT: begin
                                out_data_q    <= rs1_val;
                                out_valid_q   <= 1'b1;
                                instr_ready_q <= 1'b0;
                                state         <= OUT_WAIT;
                            end
                            OP_NOP: begin
                            end
                            default: begin
                                operand1_q    <= rs1_val;
                                operand2_q    <= rs2_val;
                                operation_q   <= {1'b0, op};
                                exec_rd       <= rd;
                                instr_ready_q <= 1'b0;
                                state         <= EXEC;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    if (exec_rd_writable) begin
                        regs[exec_rd] <= bus.alu_result;
                    end
                    instr_ready_q <= 1'b1;
                    state         <= IDLE;
                end
                OUT_WAIT: begin
                    if (bus.out_ready) begin
                        out_valid_q   <= 1'b0;
                        instr_ready_q <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    instr_ready_q <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ISSUE_ZERO_FLAG_EN
    logic zero_q;

    // Zero flag tracks only ALU writebacks; LDI, OUT and NOP leave it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_q <= 1'b0;
        end else if (state == EXEC) begin
            zero_q <= (bus.alu_result == '0);
        end
    end

    assign bus.zero_flag = zero_q;
`else
    assign bus.zero_flag = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_unit
// Directed bench for alu_issue_unit. Two instances share one instruction
// stream: an 8-register unit and a 4-register unit. The bench supplies its
// own combinational ALU for each instance.
// ---------------------------------------------------------------------------
module tb_alu_issue_unit;

`ifdef ALU_ISSUE_ZERO_FLAG_EN
    localparam bit ZF_EN = 1'b1;
`else
    localparam bit ZF_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    alu_issue_if #(.DATA_WIDTH(16)) bus ();
    alu_issue_if #(.DATA_WIDTH(16)) bus4 ();

    alu_issue_unit #(.DATA_WIDTH(16), .REG_COUNT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    alu_issue_unit #(.DATA_WIDTH(16), .REG_COUNT(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    // The small unit follows the main instance's instruction stream.
    assign bus4.instr       = bus.instr;
    assign bus4.instr_valid = bus.instr_valid;
    assign bus4.out_ready   = bus.out_ready;

    function automatic logic [15:0] alu_model(input logic [3:0] op,
                                              input logic [15:0] a,
                                              input logic [15:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return 16'h0000;
        endcase
    endfunction

    assign bus.alu_result  = alu_model(bus.alu_operation, bus.alu_operand1, bus.alu_operand2);
    assign bus4.alu_result = alu_model(bus4.alu_operation, bus4.alu_operand1, bus4.alu_operand2);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] w_alu(input logic [2:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 4'b0000};
    endfunction

    function automatic logic [15:0] w_ldi(input logic [2:0] rd, input logic [7:0] imm);
        return {3'b101, rd, 2'b00, imm};
    endfunction

    function automatic logic [15:0] w_out(input logic [2:0] rs);
        return {3'b110, 3'b000, rs, 7'b0000000};
    endfunction

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic issue(input logic [15:0] w);
        int waited;
        waited = 0;
        bus.instr       = w;
        bus.instr_valid = 1'b1;
        while (bus.instr_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            checks++;
            errors++;
            $display("[TB] FAIL issue_timeout: instr_ready=%b required 1 within 20 cycles", bus.instr_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
    endtask

    task automatic alu_op(input logic [15:0] w);
        issue(w);
        @(negedge clk);
    endtask

    // Emits a register from both units and completes the output handshake.
    task automatic read_reg(input logic [2:0] rs, output logic [15:0] d8,
                            output logic [15:0] d4, output logic v);
        issue(w_out(rs));
        d8            = bus.out_data;
        d4            = bus4.out_data;
        v             = bus.out_valid;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        bus.instr       = 16'hE000;
        bus.instr_valid = 1'b0;
        bus.out_ready   = 1'b0;
        #2;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b need 0", bus.out_valid); end
        checks++;
        if (bus.out_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_out_data: got %h need 0000", bus.out_data); end
        checks++;
        if (bus.alu_operation !== 4'h0) begin errors++; $display("[TB] FAIL reset_operation: got %h need 0", bus.alu_operation); end
        checks++;
        if (bus.instr_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_instr_ready: got %b need 0", bus.instr_ready); end
        checks++;
        if (bus.zero_flag !== 1'b0) begin errors++; $display("[TB] FAIL reset_zero_flag: got %b need 0", bus.zero_flag); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.instr_ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_reset: got %b need 1", bus.instr_ready); end
        @(negedge clk);
    endtask

    task automatic test_add();
        logic [15:0] d8, d4;
        logic        v;
        issue(w_ldi(3'd1, 8'h05));
        issue(w_ldi(3'd2, 8'h03));
        issue(w_alu(3'b000, 3'd3, 3'd1, 3'd2));
        checks++;
        if (bus.alu_operand1 !== 16'h0005) begin errors++; $display("[TB] FAIL add_operand1: got %h need 0005", bus.alu_operand1); end
        checks++;
        if (bus.alu_operand2 !== 16'h0003) begin errors++; $display("[TB] FAIL add_operand2: got %h need 0003", bus.alu_operand2); end
        checks++;
        if (bus.alu_operation !== 4'h0) begin errors++; $display("[TB] FAIL add_operation: got %h need 0", bus.alu_operation); end
        checks++;
        if (bus.instr_ready !== 1'b0) begin errors++; $display("[TB] FAIL add_ready_in_exec: got %b need 0", bus.instr_ready); end
        @(negedge clk);
        read_reg(3'd3, d8, d4, v);
        checks++;
        if (v !== 1'b1) begin errors++; $display("[TB] FAIL add_out_valid: got %b need 1", v); end
        checks++;
        if (d8 !== 16'h0008) begin errors++; $display("[TB] FAIL add_out_data: got %h need 0008", d8); end
    endtask

    task automatic test_sub_wrap();
        logic [15:0] d8, d4;
        logic        v;
        issue(w_ldi(3'd1, 8'h00));
        issue(w_ldi(3'd2, 8'h01));
        alu_op(w_alu(3'b001, 3'd3, 3'd1, 3'd2));
        checks++;
        if (bus.zero_flag !== 1'b0) begin errors++; $display("[TB] FAIL sub_zero_flag: got %b need 0", bus.zero_flag); end
        read_reg(3'd3, d8, d4, v);
        checks++;
        if (d8 !== 16'hFFFF) begin errors++; $display("[TB] FAIL sub_wrap: got %h need ffff", d8); end
        alu_op(w_alu(3'b100, 3'd4, 3'd3, 3'd3));
        checks++;
        if (bus.zero_flag !== ZF_EN) begin errors++; $display("[TB] FAIL xor_zero_flag: got %b need %b", bus.zero_flag, ZF_EN); end
        issue(w_ldi(3'd5, 8'h12));
        checks++;
        if (bus.zero_flag !== ZF_EN) begin errors++; $display("[TB] FAIL ldi_keeps_zero_flag: got %b need %b", bus.zero_flag, ZF_EN); end
        read_reg(3'd4, d8, d4, v);
        checks++;
        if (d8 !== 16'h0000) begin errors++; $display("[TB] FAIL xor_out_data: got %h need 0000", d8); end
    endtask

    task automatic test_reset_mid_exec();
        logic [15:0] d8, d4;
        logic        v;
        issue(w_ldi(3'd1, 8'h07));
        issue(w_ldi(3'd2, 8'h09));
        issue(w_alu(3'b000, 3'd5, 3'd1, 3'd2));
        reset = 1'b1;
        #1;
        checks++;
        if (bus.alu_operand1 !== 16'h0000 || bus.alu_operand2 !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL midreset_operands: got %h %h need 0000 0000", bus.alu_operand1, bus.alu_operand2);
        end
        checks++;
        if (bus.alu_operation !== 4'h0) begin errors++; $display("[TB] FAIL midreset_operation: got %h need 0", bus.alu_operation); end
        checks++;
        if (bus.zero_flag !== 1'b0 || bus.out_valid !== 1'b0 || bus.instr_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_flags: zf=%b ov=%b ir=%b need 0 0 0", bus.zero_flag, bus.out_valid, bus.instr_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        read_reg(3'd5, d8, d4, v);
        checks++;
        if (d8 !== 16'h0000) begin errors++; $display("[TB] FAIL midreset_r5: got %h need 0000", d8); end
        read_reg(3'd1, d8, d4, v);
        checks++;
        if (d8 !== 16'h0000) begin errors++; $display("[TB] FAIL midreset_r1: got %h need 0000", d8); end
    endtask

    task automatic test_out_wait();
        issue(w_ldi(3'd1, 8'h5A));
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.instr_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL idle_out_ready: ov=%b ir=%b need 0 1", bus.out_valid, bus.instr_ready);
        end
        bus.out_ready = 1'b0;
        issue(w_out(3'd1));
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h005A || bus.instr_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL out_hold[%0d]: ov=%b od=%h ir=%b need 1 005a 0", i, bus.out_valid, bus.out_data, bus.instr_ready);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL out_release_valid: got %b need 0", bus.out_valid); end
        checks++;
        if (bus.instr_ready !== 1'b1) begin errors++; $display("[TB] FAIL out_release_ready: got %b need 1", bus.instr_ready); end
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [4];
        logic [4:0]  exp_ready;
        logic [15:0] d8, d4;
        logic        v;
        logic        r;
        int          p;
        int          cyc;
        words[0]  = w_ldi(3'd1, 8'hF0);
        words[1]  = w_ldi(3'd2, 8'h3C);
        words[2]  = w_alu(3'b010, 3'd3, 3'd1, 3'd2);
        words[3]  = w_alu(3'b011, 3'd4, 3'd1, 3'd2);
        exp_ready = 5'b10111;
        p   = 0;
        cyc = 0;
        while (p < 4 && cyc < 20) begin
            bus.instr       = words[p];
            bus.instr_valid = 1'b1;
            if (cyc < 5) begin
                checks++;
                if (bus.instr_ready !== exp_ready[cyc]) begin
                    errors++;
                    $display("[TB] FAIL b2b_ready[%0d]: got %b need %b", cyc, bus.instr_ready, exp_ready[cyc]);
                end
            end
            r = bus.instr_ready;
            @(posedge clk);
            if (r === 1'b1) p++;
            cyc++;
            @(negedge clk);
        end
        bus.instr_valid = 1'b0;
        checks++;
        if (cyc !== 5) begin errors++; $display("[TB] FAIL b2b_cycles: got %0d need 5", cyc); end
        checks++;
        if (bus.instr_ready !== 1'b0 || bus.alu_operation !== 4'h3) begin
            errors++;
            $display("[TB] FAIL b2b_or_exec: ir=%b op=%h need 0 3", bus.instr_ready, bus.alu_operation);
        end
        @(negedge clk);
        read_reg(3'd3, d8, d4, v);
        checks++;
        if (d8 !== 16'h0030) begin errors++; $display("[TB] FAIL b2b_and: got %h need 0030", d8); end
        read_reg(3'd4, d8, d4, v);
        checks++;
        if (d8 !== 16'h00FC) begin errors++; $display("[TB] FAIL b2b_or: got %h need 00fc", d8); end
    endtask

    task automatic test_reg_count();
        logic [15:0] d8, d4;
        logic        v;
        issue(w_ldi(3'd6, 8'hAA));
        read_reg(3'd6, d8, d4, v);
        checks++;
        if (d8 !== 16'h00AA) begin errors++; $display("[TB] FAIL rc8_r6: got %h need 00aa", d8); end
        checks++;
        if (d4 !== 16'h0000) begin errors++; $display("[TB] FAIL rc4_r6: got %h need 0000", d4); end
        issue(w_ldi(3'd3, 8'h77));
        read_reg(3'd3, d8, d4, v);
        checks++;
        if (d4 !== 16'h0077) begin errors++; $display("[TB] FAIL rc4_r3: got %h need 0077", d4); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        $display("[TB] starting alu_issue_unit bench");
        test_reset();
        test_add();
        test_sub_wrap();
        test_reset_mid_exec();
        test_out_wait();
        test_back_to_back();
        test_reg_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Sequential initiator for the 16-bit combinational ALU: accepts instruction words over a valid/ready handshake and decodes them.
- Holds an internal register file, drives the ALU operand/operation inputs, samples the ALU result and writes it back.
- Streams selected register values out over a second valid/ready port.
- Sits between an instruction source (UART/ROM sequencer) and the ALU instance.

Parameters:
- DATA_WIDTH, 16, register, ALU operand and output data width.
- REG_COUNT, 8, number of registers; legal range 2..8; indices >= REG_COUNT read 0, writes ignored.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- instr  input  16  instruction word.
- instr_valid  input  1  instr is valid.
- instr_ready  output  1  unit can accept instr this cycle.
- alu_operand1  output  DATA_WIDTH  to ALU operand1.
- alu_operand2  output  DATA_WIDTH  to ALU operand2.
- alu_operation  output  4  to ALU operation.
- alu_result  input  DATA_WIDTH  from ALU result (combinational).
- out_data  output  DATA_WIDTH  register value being emitted.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- zero_flag  output  1  result of last ALU op was zero (see Optional Feature).

Behaviour:
- Encoding: op = instr[15:13], rd = instr[12:10], rs1 = instr[9:7], rs2 = instr[6:4], imm = instr[7:0].
  - op 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR: rd <= rs1 op rs2.
  - op 101 LDI: rd <= zero-extended imm.
  - op 110 OUT: emit register rs1.
  - op 111 NOP.
- Handshake: transfer occurs when instr_valid && instr_ready. instr_ready = 1 only in IDLE. instr is held stable by the source only while valid.
- States:
  - IDLE: on transfer, latch the decoded fields.
    - ALU op -> EXEC.
    - LDI -> write rd this edge, stay IDLE.
    - OUT -> load out_data with reg[rs1], set out_valid, -> OUT_WAIT.
    - NOP -> stay IDLE.
  - EXEC (1 cycle): alu_operand1 = reg[rs1], alu_operand2 = reg[rs2], alu_operation = {1'b0, op}. At the clock edge ending EXEC, write alu_result into rd, then -> IDLE.
  - OUT_WAIT: hold out_data and out_valid until out_ready = 1; on that edge clear out_valid, -> IDLE.
- ALU ports are registered from the latched fields and are stable for the whole EXEC cycle. Outside EXEC they hold their last values; operation output is 4'b0000 after reset.
- Throughput:
  - ALU op: 2 cycles per instruction (accept, EXEC); next accept on the cycle after EXEC.
  - LDI/NOP: 1 instruction per cycle.
  - OUT: at least 2 cycles.
- Hazards: none. Serialization guarantees writeback completes before the next instruction is read. rd == rs1 == rs2 is legal.
- Arithmetic wraps modulo 2^DATA_WIDTH; the wrap comes from the ALU and is passed through unmodified.
- Reset (any time, including mid-EXEC or OUT_WAIT):
  - state -> IDLE, all registers 0, out_valid 0, out_data 0, alu_operand1/2 0, alu_operation 0, zero_flag 0.
  - instr_ready is 1 on the first edge after reset deasserts.
  - An in-flight instruction is dropped with no writeback.
- instr_valid during a non-IDLE state is ignored (not consumed).
- out_ready asserted with out_valid = 0 has no effect.

Optional Feature:
- Macro ALU_ISSUE_ZERO_FLAG_EN.
- Defined: zero_flag register updates at the EXEC writeback edge to (alu_result == 0). LDI, OUT and NOP leave it unchanged. Reset clears it to 0.
- Undefined: zero_flag is tied to constant 0 and no comparator logic exists.

Test Plan:
- LDI r1,0x05; LDI r2,0x03; ADD r3,r1,r2; OUT r3 -> during EXEC alu_operand1 = 5, alu_operand2 = 3, alu_operation = 0; out_data = 0x0008 with out_valid = 1.
- LDI r1,0x00; LDI r2,0x01; SUB r3,r1,r2; OUT r3 -> out_data = 0xFFFF (wrap). With flag macro: zero_flag = 0. XOR r4,r3,r3 -> zero_flag = 1, OUT r4 = 0x0000.
- OUT r1 with out_ready held 0 for 5 cycles, then 1 -> out_valid and out_data stable for all 5 cycles; instr_ready = 0 throughout; instr_ready = 1 the cycle after acceptance.
- Back-to-back instr_valid stream (LDI, AND, OR) -> instr_ready low only during EXEC; no instruction lost or duplicated; AND 0xF0 & 0x3C = 0x30, OR = 0xFC.
- Reset asserted mid-EXEC of ADD r5,... -> r5 reads 0 via a later OUT; all outputs 0 asynchronously during reset.
- REG_COUNT = 4: LDI r6,0xAA then OUT r6 -> out_data = 0x0000.
